conv_out_scheduler: RTL and testbench

- Sequencer for a folded 2D-convolution engine: one shared multiply-tree core computes one output pixel per issue instead of one core per output.
- Walks every output coordinate (d, h, w) in a fixed order and issues the window base address plus a sequence tag into the core.
- Bounds in-flight work with a credit limit and counts in-order retirements from the core's output side.
- Sits between the host start/done interface and the multiply core / image-window mux.

---
 rtl/conv_out_scheduler_if.sv | 76 +++++++
 rtl/conv_out_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_conv_out_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_out_scheduler_if.sv
// conv_out_scheduler_if
//   Handshake bundle between the convolution output scheduler, the host
//   start/done side and the shared multiply core.
//
//   Parameters mirror the scheduler so that every field width is derived the
//   same way on both sides of the bundle.
//
//   Signals (master = scheduler side):
//     start        host -> sched   begin a frame
//     busy, done   sched -> host   frame in progress / one-cycle completion pulse
//     issue_*      sched -> core   issue beat: filter index, window origin,
//                                  linear result index, sequence tag
//     ret_valid    core -> sched   result emerging from the core
//     ret_tag      core -> sched   opaque tag field emerging with the result
//     inflight     sched -> host   outstanding (issued, not retired) count
//     err          sched -> host   sticky tag mismatch flag, present only when
//                                  CONV_OUT_SCHEDULER_TAG_CHECK_EN is defined
interface conv_out_scheduler_if #(
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int FILTER_W     = 3,
  parameter int FILTER_H     = 3,
  parameter int RESULT_D     = 4,
  parameter int STRIDE_W     = 1,
  parameter int STRIDE_H     = 1,
  parameter int MAX_INFLIGHT = 16
);
  localparam int RESULT_W  = (IMG_W - FILTER_W) / STRIDE_W + 1;
  localparam int RESULT_H  = (IMG_H - FILTER_H) / STRIDE_H + 1;
  localparam int TOTAL     = RESULT_D * RESULT_H * RESULT_W;
  localparam int IDX_WIDTH = $clog2(TOTAL + 1);
  localparam int D_W       = (RESULT_D > 1) ? $clog2(RESULT_D) : 1;
  localparam int IH_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int INF_W     = $clog2(MAX_INFLIGHT + 1);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 issue_valid;
  logic [D_W-1:0]       issue_d;
  logic [IH_W-1:0]      issue_img_h;
  logic [IW_W-1:0]      issue_img_w;
  logic [IDX_WIDTH-1:0] issue_idx;
  logic [7:0]           issue_tag;
  logic                 ret_valid;
  logic [7:0]           ret_tag;
  logic [INF_W-1:0]     inflight;
`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
  logic                 err;

  modport master (
    input  start, ret_valid, ret_tag,
    output busy, done, issue_valid, issue_d, issue_img_h, issue_img_w,
           issue_idx, issue_tag, inflight, err
  );

  modport slave (
    output start, ret_valid, ret_tag,
    input  busy, done, issue_valid, issue_d, issue_img_h, issue_img_w,
           issue_idx, issue_tag, inflight, err
  );
`else
  modport master (
    input  start, ret_valid, ret_tag,
    output busy, done, issue_valid, issue_d, issue_img_h, issue_img_w,
           issue_idx, issue_tag, inflight
  );

  modport slave (
    output start, ret_valid, ret_tag,
    input  busy, done, issue_valid, issue_d, issue_img_h, issue_img_w,
           issue_idx, issue_tag, inflight
  );
`endif
endinterface

// File: rtl/conv_out_scheduler.sv
// conv_out_scheduler
//   Sequencer for a folded 2D convolution: a single shared multiply-tree core
//   computes one output pixel per issue. The scheduler walks every output
//   coordinate in (d, h, w) order (w fastest), issues the window origin and a
//   sequence tag, caps outstanding work at MAX_INFLIGHT and counts in-order
//   retirements until the whole frame has come back.
//
//   Ports:
//     clk     clock
//     reset   synchronous, active-high
//     bus     conv_out_scheduler_if.master (start/busy/done, issue_*,
//             ret_valid/ret_tag, inflight, optional err)
//
//   Optional feature: define CONV_OUT_SCHEDULER_TAG_CHECK_EN to add an
//   expected-tag counter that checks every counted return and raises a sticky
//   err on mismatch. err never influences sequencing.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; returns are ignored
//   RUN    | issuing one beat per cycle while a credit is available
//   DRAIN  | everything issued; waiting for the remaining returns
//   DONE   | one-cycle done pulse, then back to IDLE
module conv_out_scheduler #(
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int FILTER_W     = 3,
  parameter int FILTER_H     = 3,
  parameter int RESULT_D     = 4,
  parameter int STRIDE_W     = 1,
  parameter int STRIDE_H     = 1,
  parameter int MAX_INFLIGHT = 16
) (
  input logic                  clk,
  input logic                  reset,
  conv_out_scheduler_if.master bus
);
  localparam int RESULT_W  = (IMG_W - FILTER_W) / STRIDE_W + 1;
  localparam int RESULT_H  = (IMG_H - FILTER_H) / STRIDE_H + 1;
  localparam int TOTAL     = RESULT_D * RESULT_H * RESULT_W;
  localparam int IDX_WIDTH = $clog2(TOTAL + 1);
  localparam int D_W       = (RESULT_D > 1) ? $clog2(RESULT_D) : 1;
  localparam int IH_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RH_W      = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
  localparam int RW_W      = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
  localparam int INF_W     = $clog2(MAX_INFLIGHT + 1);

  localparam logic [RW_W-1:0]      W_LAST    = RW_W'(RESULT_W - 1);
  localparam logic [RH_W-1:0]      H_LAST    = RH_W'(RESULT_H - 1);
  localparam logic [D_W-1:0]       D_LAST    = D_W'(RESULT_D - 1);
  localparam logic [IW_W-1:0]      W_STEP    = IW_W'(STRIDE_W);
  localparam logic [IH_W-1:0]      H_STEP    = IH_W'(STRIDE_H);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(TOTAL - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_TOTAL = IDX_WIDTH'(TOTAL);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1);
  localparam logic [INF_W-1:0]     INF_MAX   = INF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [D_W-1:0]       d_q;
  logic [RH_W-1:0]      h_q;
  logic [RW_W-1:0]      w_q;
  logic [IH_W-1:0]      img_h_q;
  logic [IW_W-1:0]      img_w_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [7:0]           tag_q;
  logic [INF_W-1:0]     inflight_q;
  // Down-counter of results still owed by the core; the frame is complete at
  // its terminal count.
  logic [IDX_WIDTH-1:0] remaining_q;

  logic issue;
  logic load;
  logic busy;
  logic done;
  logic retire;

  // A return only counts while a frame is active and something is owed;
  // strays in IDLE/DONE or with nothing outstanding are dropped.
  assign retire = bus.ret_valid && (inflight_q != '0) &&
                  ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Credit test uses only the registered count, so a retire in this cycle
  // frees its slot for the next cycle, never the current one.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (inflight_q < INF_MAX) begin
          issue = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((remaining_q == '0) || (retire && (remaining_q == IDX_ONE))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q         <= '0;
      h_q         <= '0;
      w_q         <= '0;
      img_h_q     <= '0;
      img_w_q     <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      remaining_q <= '0;
    end else if (load) begin
      d_q         <= '0;
      h_q         <= '0;
      w_q         <= '0;
      img_h_q     <= '0;
      img_w_q     <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      remaining_q <= IDX_TOTAL;
    end else begin
      if (issue) begin
        idx_q <= idx_q + 1'b1;
        tag_q <= tag_q + 1'b1;
        // Window origin is tracked incrementally alongside the result
        // coordinate so no multiplier is needed.
        if (w_q == W_LAST) begin
          w_q     <= '0;
          img_w_q <= '0;
          if (h_q == H_LAST) begin
            h_q     <= '0;
            img_h_q <= '0;
            d_q     <= (d_q == D_LAST) ? '0 : d_q + 1'b1;
          end else begin
            h_q     <= h_q + 1'b1;
            img_h_q <= img_h_q + H_STEP;
          end
        end else begin
          w_q     <= w_q + 1'b1;
          img_w_q <= img_w_q + W_STEP;
        end
      end

      case ({issue, retire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase

      if (retire && (remaining_q != '0)) begin
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.issue_valid = issue;
  assign bus.issue_d     = d_q;
  assign bus.issue_img_h = img_h_q;
  assign bus.issue_img_w = img_w_q;
  assign bus.issue_idx   = idx_q;
  assign bus.issue_tag   = tag_q;
  assign bus.inflight    = inflight_q;

`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
  logic [7:0] exp_tag_q;
  logic       err_q;

  // The core retires in order, so every counted return must carry the next
  // tag in sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_tag_q <= '0;
      err_q     <= 1'b0;
    end else if (load) begin
      exp_tag_q <= '0;
      err_q     <= 1'b0;
    end else if (retire) begin
      if (bus.ret_tag != exp_tag_q) begin
        err_q <= 1'b1;
      end
      exp_tag_q <= exp_tag_q + 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  // Tag field is opaque to the scheduler when checking is compiled out.
  logic unused_ret_tag;
  assign unused_ret_tag = ^bus.ret_tag;
`endif

endmodule

// File: tb/tb_conv_out_scheduler.sv
module tb_conv_out_scheduler;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // bus0: default geometry, bus1: stride 2, bus2: four credits with slow core
  conv_out_scheduler_if                                 bus0 ();
  conv_out_scheduler_if #(.STRIDE_W(2), .STRIDE_H(2))   bus1 ();
  conv_out_scheduler_if #(.MAX_INFLIGHT(4))             bus2 ();

  conv_out_scheduler dut0 (.clk(clk), .reset(reset), .bus(bus0));
  conv_out_scheduler #(.STRIDE_W(2), .STRIDE_H(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  conv_out_scheduler #(.MAX_INFLIGHT(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Core models: fixed-latency delay lines from issue to return
  logic [5:0]      pv0 = '0;
  logic [5:0][7:0] pt0 = '0;
  logic [5:0]      pv1 = '0;
  logic [5:0][7:0] pt1 = '0;
  logic [9:0]      pv2 = '0;
  logic [9:0][7:0] pt2 = '0;
  int              rc0 = 0;
  int              corrupt_at = -1;
  logic            corrupt_en = 1'b0;

  always @(posedge clk) begin
    pv0 <= {pv0[4:0], bus0.issue_valid};
    pt0 <= {pt0[4:0], bus0.issue_tag};
    pv1 <= {pv1[4:0], bus1.issue_valid};
    pt1 <= {pt1[4:0], bus1.issue_tag};
    pv2 <= {pv2[8:0], bus2.issue_valid};
    pt2 <= {pt2[8:0], bus2.issue_tag};
    if (pv0[5]) rc0 <= rc0 + 1;
  end

  assign bus0.ret_valid = pv0[5];
  assign bus0.ret_tag   = pt0[5] ^ {7'd0, corrupt_en && (rc0 == corrupt_at)};
  assign bus1.ret_valid = pv1[5];
  assign bus1.ret_tag   = pt1[5];
  assign bus2.ret_valid = pv2[9];
  assign bus2.ret_tag   = pt2[9];

  // Scoreboard queues of expected beats {d, img_h, img_w, idx, tag}
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int ic0[$];
  int ic1[$];
  int ic2[$];
  int dc0[$];
  int dc1[$];
  int dc2[$];
  int max_inf2  = 0;
  int err_cyc   = -1;
  int ret20_cyc = -1;
  logic err_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] p;
    p = {4'(bus0.issue_d), 4'(bus0.issue_img_h), 4'(bus0.issue_img_w),
         12'(bus0.issue_idx), bus0.issue_tag};
    if (bus0.issue_valid) begin
      if (q0.size() == 0) check_val("b0_beat_unexpected", p, 32'hFFFF_FFFF);
      else                check_val("b0_beat", p, q0.pop_front());
      ic0.push_back(cyc);
    end
    if (bus0.done) dc0.push_back(cyc);
`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
    if (bus0.err && !err_prev) err_cyc = cyc;
    err_prev = bus0.err;
    if (bus0.ret_valid && corrupt_en && (rc0 == corrupt_at)) ret20_cyc = cyc;
`endif
  end

  always @(negedge clk) begin
    logic [31:0] p;
    p = {4'(bus1.issue_d), 4'(bus1.issue_img_h), 4'(bus1.issue_img_w),
         12'(bus1.issue_idx), bus1.issue_tag};
    if (bus1.issue_valid) begin
      if (q1.size() == 0) check_val("b1_beat_unexpected", p, 32'hFFFF_FFFF);
      else                check_val("b1_beat", p, q1.pop_front());
      ic1.push_back(cyc);
    end
    if (bus1.done) dc1.push_back(cyc);
  end

  always @(negedge clk) begin
    logic [31:0] p;
    p = {4'(bus2.issue_d), 4'(bus2.issue_img_h), 4'(bus2.issue_img_w),
         12'(bus2.issue_idx), bus2.issue_tag};
    if (bus2.issue_valid) begin
      if (q2.size() == 0) check_val("b2_beat_unexpected", p, 32'hFFFF_FFFF);
      else                check_val("b2_beat", p, q2.pop_front());
      ic2.push_back(cyc);
    end
    if (bus2.done) dc2.push_back(cyc);
    if (int'(bus2.inflight) > max_inf2) max_inf2 = int'(bus2.inflight);
  end

  task automatic push_frame(input int which, input int rd, input int rh, input int rw,
                            input int sh, input int sw);
    int idx;
    logic [31:0] e;
    idx = 0;
    for (int d = 0; d < rd; d++)
      for (int h = 0; h < rh; h++)
        for (int w = 0; w < rw; w++) begin
          e = {4'(d), 4'(h * sh), 4'(w * sw), 12'(idx), 8'(idx)};
          case (which)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
          endcase
          idx++;
        end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       bus0.start = v;
      1:       bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
  endtask

  function automatic int n_done(input int which);
    case (which)
      0:       return dc0.size();
      1:       return dc1.size();
      default: return dc2.size();
    endcase
  endfunction

  task automatic wait_done(input int which, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while ((n_done(which) < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, n_done(which), target);
  endtask

  initial begin
    int bi;
    int bd;
    int n;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_b0_ctl", {29'd0, bus0.busy, bus0.done, bus0.issue_valid}, 32'd0);
    check_val("rst_b0_inflight", 32'(bus0.inflight), 32'd0);
    check_val("rst_b0_fields", {4'(bus0.issue_d), 4'(bus0.issue_img_h), 4'(bus0.issue_img_w),
                                12'(bus0.issue_idx), bus0.issue_tag}, 32'd0);
    check_val("rst_b2_ctl", {21'd0, bus2.busy, bus2.done, bus2.issue_valid, 8'(bus2.inflight)}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Default geometry, 6-cycle core: 144 back-to-back beats
    push_frame(0, 4, 6, 6, 1, 1);
    pulse_start(0);
    wait_done(0, 1, 1000, "t1_done");
    repeat (10) @(negedge clk);
    check_val("t1_issues", ic0.size(), 144);
    check_val("t1_done_after_last_issue", dc0[0] - ic0[143], 7);
    check_val("t1_done_once", dc0.size(), 1);
    check_val("t1_sb_empty", q0.size(), 0);
    check_val("t1_idle_busy", {31'd0, bus0.busy}, 32'd0);
`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
    check_val("t1_err_clean", {31'd0, bus0.err}, 32'd0);
`endif

    // Stride 2: 3x3 windows per filter, 36 beats
    push_frame(1, 4, 3, 3, 2, 2);
    pulse_start(1);
    wait_done(1, 1, 1000, "t2_done");
    repeat (10) @(negedge clk);
    check_val("t2_issues", ic1.size(), 36);
    check_val("t2_done_once", dc1.size(), 1);
    check_val("t2_sb_empty", q1.size(), 0);

    // Four credits, 10-cycle core: bursts of 4, then one issue per retire
    push_frame(2, 4, 6, 6, 1, 1);
    pulse_start(2);
    wait_done(2, 1, 4000, "t3_done");
    repeat (15) @(negedge clk);
    check_val("t3_issues", ic2.size(), 144);
    check_val("t3_first_burst", ic2[3] - ic2[0], 3);
    check_val("t3_stall_gap", ic2[4] - ic2[0], 11);
    check_val("t3_second_gap", ic2[8] - ic2[4], 11);
    check_val("t3_max_inflight", max_inf2, 4);
    check_val("t3_sb_empty", q2.size(), 0);

`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
    // Corrupt the 20th return of a frame
    bd = dc0.size();
    bi = ic0.size();
    corrupt_at = rc0 + 19;
    corrupt_en = 1'b1;
    push_frame(0, 4, 6, 6, 1, 1);
    pulse_start(0);
    wait_done(0, bd + 1, 1000, "t6_done");
    repeat (3) @(negedge clk);
    check_val("t6_err_delay", err_cyc - ret20_cyc, 1);
    check_val("t6_err_sticky", {31'd0, bus0.err}, 32'd1);
    check_val("t6_issues", ic0.size() - bi, 144);
    corrupt_en = 1'b0;
`endif

    // start held high across a whole frame: exactly one frame, next one
    // only after the return to IDLE
    bd = dc0.size();
    bi = ic0.size();
    push_frame(0, 4, 6, 6, 1, 1);
    push_frame(0, 4, 6, 6, 1, 1);
    @(negedge clk);
    bus0.start = 1'b1;
    wait_done(0, bd + 1, 1000, "t5_done1");
`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
    check_val("t5_err_cleared", {31'd0, bus0.err}, 32'd0);
`endif
    n = 0;
    while ((ic0.size() < bi + 145) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    bus0.start = 1'b0;
    wait_done(0, bd + 2, 1000, "t5_done2");
    repeat (10) @(negedge clk);
    check_val("t5_issues", ic0.size() - bi, 288);
    check_val("t5_restart_gap", ic0[bi + 144] - dc0[bd], 2);
    check_val("t5_done_count", dc0.size() - bd, 2);
    check_val("t5_sb_empty", q0.size(), 0);

    // Reset in the middle of a frame, late returns, then a clean frame
    bd = dc0.size();
    bi = ic0.size();
    push_frame(0, 4, 6, 6, 1, 1);
    pulse_start(0);
    n = 0;
    while ((ic0.size() < bi + 50) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check_val("t4_reached_50", (ic0.size() >= bi + 50) ? 32'd1 : 32'd0, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("t4_rst_ctl", {29'd0, bus0.busy, bus0.done, bus0.issue_valid}, 32'd0);
    check_val("t4_rst_inflight", 32'(bus0.inflight), 32'd0);
    q0.delete();
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check_val("t4_late_ret_inflight", 32'(bus0.inflight), 32'd0);
    check_val("t4_late_ret_busy", {31'd0, bus0.busy}, 32'd0);
`ifdef CONV_OUT_SCHEDULER_TAG_CHECK_EN
    check_val("t4_err_after_reset", {31'd0, bus0.err}, 32'd0);
`endif
    bi = ic0.size();
    push_frame(0, 4, 6, 6, 1, 1);
    pulse_start(0);
    wait_done(0, bd + 1, 1000, "t4_done");
    repeat (10) @(negedge clk);
    check_val("t4_issues", ic0.size() - bi, 144);
    check_val("t4_sb_empty", q0.size(), 0);
    check_val("t4_done_once", dc0.size() - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
